offchip_traffic_monitor: RTL and testbench
==========================================

// Module: offchip_traffic_monitor
// PURPOSE
// Synthesizable, parametrised counter of off-chip handshake beats. NUM_CH valid/ready channels feed it
// (activations, masks, weights, encoded out, mask out, ...). Tie ready high on output channels.
// Keeps a saturating beat count per channel, a cost-weighted energy total and a window cycle count.
// Supports start/stop and an optional fixed window. A registered read port exposes all results.
// PARAMETERS
// NUM_CH     5   number of monitored channels (1..16)
// CNT_W      32  width of each per-channel beat counter and of the cycle counter
// COST_W     8   width of each per-channel energy cost per beat (unsigned)
// ACC_W      40  width of energy accumulator and rd_data (ACC_W >= CNT_W)
// WINDOW_CYC 0   0 = run until stop; N>0 = auto-stop after exactly N RUN cycles
// PORTS
// clk       in  1                clock, all logic on posedge
// rst       in  1                synchronous active-high reset
// ch_valid  in  NUM_CH           per-channel valid
// ch_ready  in  NUM_CH           per-channel ready; beat(i) = ch_valid[i] & ch_ready[i]
// ch_cost   in  NUM_CH*COST_W    cost of one beat, channel i at [i*COST_W +: COST_W]; static during RUN
// start     in  1                pulse: clear all results and enter RUN
// stop      in  1                pulse: freeze results (RUN -> HOLD)
// busy      out 1                high in RUN
// done      out 1                one-cycle pulse on every entry to HOLD
// overflow  out NUM_CH+2         sticky saturation flags: [i] = chan i, [NUM_CH] = energy, [NUM_CH+1] = cycles
// rd_en     in  1                read request
// rd_sel    in  $clog2(NUM_CH+2) 0..NUM_CH-1 beats(i); NUM_CH energy; NUM_CH+1 cycle count
// rd_data   out ACC_W            read result, zero-extended
// rd_valid  out 1                high one cycle after rd_en
// BEHAVIOUR
// - Clock is clk; reset is rst, synchronous and active-high.
// - Reset: state IDLE; all counters, energy, overflow = 0; busy = 0, done = 0, rd_valid = 0, rd_data = 0.
// - States: IDLE, RUN, HOLD.
//   - start (any state) -> RUN next cycle, all results and overflow cleared.
//   - stop in RUN -> HOLD. stop in IDLE/HOLD is ignored.
//   - RUN with WINDOW_CYC > 0 and cycle count == WINDOW_CYC-1 (pre-increment) -> HOLD.
//   - start and stop in the same cycle: start wins.
// - Counting happens only in cycles where state == RUN and start is low.
//   - Beats in the start cycle are not counted.
//   - Beats in the stop cycle and in the final auto-window cycle are counted.
// - Per RUN cycle:
//   - cycle count += 1;
//   - beats(i) += beat(i);
//   - energy += sum over i of beat(i)*ch_cost(i). The sum is computed at ACC_W width, so there is no internal overflow.
// - Saturation: any counter that would exceed all-ones holds at all-ones and sets its overflow bit.
//   The bit stays set until start or rst. No wrap-around ever.
// - done = 1 for exactly the first cycle the state is HOLD. busy = (state == RUN), registered.
// - Read port:
//   - rd_en at cycle t -> rd_valid = 1 and rd_data = selected value at t+1.
//   - The value is taken before the update of cycle t, so a RUN-time read returns the live value.
//   - Reads are legal in all states. rd_en asserted every cycle gives one result per cycle.
//   - rd_sel > NUM_CH+1 -> rd_data = 0 with rd_valid = 1.
//   - rd_data holds its value when rd_valid = 0.
// - rst mid-RUN: all results are lost, state IDLE next cycle, rd_valid = 0.
// - ch_cost changes during RUN take effect in the same cycle (combinational use).
// TESTING
// 1. rst then idle; toggle ch_valid/ch_ready -> all reads 0, busy = 0, done never pulses.
// 2. NUM_CH=5, costs {1,2,3,4,5}; start, then 10 cycles with ch0 & ch2 beating each cycle, then stop with a beat in the stop cycle
//    -> beats0 = beats2 = 11, energy = 44, cycles = 11, done pulse 1 cycle.
// 3. WINDOW_CYC=8, all channels valid & ready, start, no stop
//    -> HOLD after 8 RUN cycles; every beats(i) = 8; cycles = 8; busy low afterwards.
// 4. CNT_W=4, ch1 beating 20 cycles -> beats1 = 15, overflow[1] = 1; a new start clears both to 0.
// 5. start and stop in the same cycle while in RUN -> counters cleared, stays RUN, no done.
//    rst mid-RUN -> IDLE next cycle, all reads 0.
// 6. Back-to-back rd_en sweeping rd_sel 0..NUM_CH+2 in HOLD -> one rd_valid per request at +1 cycle, correct values, sel NUM_CH+2 returns 0.

Source files
------------

// File: rtl/offchip_traffic_monitor.sv
// ---------------------------------------------------------------------------
// offchip_traffic_monitor
//
// Counts handshake beats on NUM_CH off-chip valid/ready channels. For every
// channel it keeps a saturating beat counter. It also keeps a cost-weighted
// energy total and a count of RUN cycles. start/stop pulses control the
// measurement window. An optional fixed window (WINDOW_CYC > 0) stops the run
// automatically. A registered read port returns any result.
//
// Ports
//   clk, rst   clock and synchronous active-high reset
//   ch_valid   per-channel valid            [NUM_CH]
//   ch_ready   per-channel ready            [NUM_CH]
//   ch_cost    per-beat cost, chan i at [i*COST_W +: COST_W]
//   start      clear all results and enter RUN (wins over stop)
//   stop       RUN -> HOLD, ignored in other states
//   busy       high while in RUN
//   done       one-cycle pulse on each entry to HOLD
//   overflow   sticky saturation flags: [i] chan i, [NUM_CH] energy,
//              [NUM_CH+1] cycle count
//   rd_en      read request, result one cycle later
//   rd_sel     0..NUM_CH-1 beats(i), NUM_CH energy, NUM_CH+1 cycles
//   rd_data    read result, zero-extended, held when no read
//   rd_valid   high one cycle after rd_en
// ---------------------------------------------------------------------------

// Saturating up-counter with a sticky overflow flag. It is used for each
// channel and for the cycle counter.
module otm_sat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         ovf
);
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else if (inc) begin
            // Hold at all-ones and never wrap.
            if (&cnt) ovf <= 1'b1;
            else      cnt <= cnt + 1'b1;
        end
    end
endmodule

module offchip_traffic_monitor #(
    parameter int NUM_CH     = 5,
    parameter int CNT_W      = 32,
    parameter int COST_W     = 8,
    parameter int ACC_W      = 40,
    parameter int WINDOW_CYC = 0,
    localparam int SEL_W     = $clog2(NUM_CH + 2)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        ch_valid,
    input  logic [NUM_CH-1:0]        ch_ready,
    input  logic [NUM_CH*COST_W-1:0] ch_cost,
    input  logic                     start,
    input  logic                     stop,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH+1:0]        overflow,
    input  logic                     rd_en,
    input  logic [SEL_W-1:0]         rd_sel,
    output logic [ACC_W-1:0]         rd_data,
    output logic                     rd_valid
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t state, state_nxt;

    logic [NUM_CH-1:0]            beat;
    logic [NUM_CH-1:0][CNT_W-1:0] beats;
    logic [NUM_CH-1:0]            beat_ovf;
    logic [CNT_W-1:0]             cyc_cnt;
    logic                         cyc_ovf;
    logic [ACC_W-1:0]             energy;
    logic                         energy_ovf;
    logic [ACC_W-1:0]             beat_sum;
    logic [ACC_W:0]               energy_sum;
    logic                         count_en;
    logic                         win_hit;
    logic [ACC_W-1:0]             sel_val;

    assign beat = ch_valid & ch_ready;

    // A start cycle only clears. It never counts, even when already in RUN.
    assign count_en = (state == RUN) && !start;

    // The window ends on the cycle whose pre-increment count is WINDOW_CYC-1.
    // That cycle's beats still count.
    generate
        if (WINDOW_CYC > 0) begin : g_win
            assign win_hit = (cyc_cnt == CNT_W'(WINDOW_CYC - 1));
        end else begin : g_nowin
            assign win_hit = 1'b0;
        end
    endgenerate

    // ---------------- state machine ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (start)
            state_nxt = RUN;
        else if (state == RUN && (stop || win_hit))
            state_nxt = HOLD;
    end

    // busy and done are registered from the next state, so they line up
    // with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN);
            done <= (state_nxt == HOLD) && (state != HOLD);
        end
    end

    // ---------------- per-channel beat counters ----------------
    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
            otm_sat_cnt #(.W(CNT_W)) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (start),
                .inc (count_en & beat[g]),
                .cnt (beats[g]),
                .ovf (beat_ovf[g])
            );
        end
    endgenerate

    otm_sat_cnt #(.W(CNT_W)) u_cyc (
        .clk (clk),
        .rst (rst),
        .clr (start),
        .inc (count_en),
        .cnt (cyc_cnt),
        .ovf (cyc_ovf)
    );

    // ---------------- energy accumulator ----------------
    // The per-cycle sum is built at ACC_W width. One extra bit on the final
    // add catches saturation of the running total.
    always_comb begin
        beat_sum = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (beat[i])
                beat_sum = beat_sum + ACC_W'(ch_cost[i*COST_W +: COST_W]);
        end
    end

    assign energy_sum = {1'b0, energy} + {1'b0, beat_sum};

    always_ff @(posedge clk) begin
        if (rst || start) begin
            energy     <= '0;
            energy_ovf <= 1'b0;
        end else if (count_en) begin
            if (energy_sum[ACC_W]) begin
                energy     <= '1;
                energy_ovf <= 1'b1;
            end else begin
                energy <= energy_sum[ACC_W-1:0];
            end
        end
    end

    assign overflow = {cyc_ovf, energy_ovf, beat_ovf};

    // ---------------- read port ----------------
    // The mux reads the registers before this cycle's update, so a read
    // during RUN returns the live value.
    always_comb begin
        sel_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rd_sel == SEL_W'(i))
                sel_val = ACC_W'(beats[i]);
        end
        if (rd_sel == SEL_W'(NUM_CH))
            sel_val = energy;
        if (rd_sel == SEL_W'(NUM_CH + 1))
            sel_val = ACC_W'(cyc_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en)
                rd_data <= sel_val;
        end
    end
endmodule

// File: tb/tb_offchip_traffic_monitor.sv
// Bench for offchip_traffic_monitor. Three instances share one stimulus
// stream. Instance 0 has the default parameters. Instance 1 uses
// WINDOW_CYC=8. Instance 2 uses CNT_W=4. A per-instance model made of plain
// counters predicts every registered output, and a compare process checks
// those outputs on each falling edge. Directed literal reads pin the model.
module tb_offchip_traffic_monitor;
    localparam int NCH = 5;
    localparam int NI  = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NCH-1:0]  ch_valid = '0;
    logic [NCH-1:0]  ch_ready = '0;
    logic [NCH*8-1:0] ch_cost = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    logic            start = 1'b0;
    logic            stop = 1'b0;
    logic            rd_en = 1'b0;
    logic [2:0]      rd_sel = '0;

    logic [NI-1:0]   busy, done, rdv;
    logic [6:0]      ovf [NI];
    logic [39:0]     rdd [NI];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    offchip_traffic_monitor #(.NUM_CH(NCH), .CNT_W(32), .COST_W(8), .ACC_W(40), .WINDOW_CYC(0)) u0 (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_cost(ch_cost),
        .start(start), .stop(stop), .busy(busy[0]), .done(done[0]), .overflow(ovf[0]),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdd[0]), .rd_valid(rdv[0]));
    offchip_traffic_monitor #(.NUM_CH(NCH), .CNT_W(32), .COST_W(8), .ACC_W(40), .WINDOW_CYC(8)) u1 (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_cost(ch_cost),
        .start(start), .stop(stop), .busy(busy[1]), .done(done[1]), .overflow(ovf[1]),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdd[1]), .rd_valid(rdv[1]));
    offchip_traffic_monitor #(.NUM_CH(NCH), .CNT_W(4), .COST_W(8), .ACC_W(40), .WINDOW_CYC(0)) u2 (
        .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_cost(ch_cost),
        .start(start), .stop(stop), .busy(busy[2]), .done(done[2]), .overflow(ovf[2]),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_data(rdd[2]), .rd_valid(rdv[2]));

    // ---------------- model ----------------
    // Phase of each instance: 0 idle, 1 running, 2 holding.
    int      m_ph  [NI];
    longint  m_cnt [NI][NCH];
    longint  m_en  [NI];
    longint  m_cy  [NI];
    logic [6:0] m_ovf [NI];
    bit      m_busy[NI], m_done[NI], m_rdv[NI];
    longint  m_rdd [NI];
    longint  cmax  [NI] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 15};
    int      win   [NI] = '{0, 8, 0};
    longint  emax  = 64'hFF_FFFF_FFFF;

    function automatic longint mval(int k, int sel);
        if (sel < NCH)      return m_cnt[k][sel];
        if (sel == NCH)     return m_en[k];
        if (sel == NCH + 1) return m_cy[k];
        return 0;
    endfunction

    task automatic model_clear(int k);
        for (int i = 0; i < NCH; i++) m_cnt[k][i] = 0;
        m_en[k] = 0; m_cy[k] = 0; m_ovf[k] = '0;
    endtask

    task automatic model_step(int k);
        int prev;
        bit last;
        longint e;
        logic [NCH-1:0] bt;
        bt = ch_valid & ch_ready;
        if (rst) begin
            model_clear(k);
            m_ph[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_rdv[k] = 0; m_rdd[k] = 0;
            return;
        end
        m_rdv[k] = rd_en;
        if (rd_en) m_rdd[k] = mval(k, int'(rd_sel));
        prev = m_ph[k];
        if (start) begin
            model_clear(k);
            m_ph[k] = 1;
        end else if (m_ph[k] == 1) begin
            last = stop || (win[k] > 0 && m_cy[k] == win[k] - 1);
            if (m_cy[k] == cmax[k]) m_ovf[k][NCH+1] = 1'b1; else m_cy[k]++;
            e = m_en[k];
            for (int i = 0; i < NCH; i++) begin
                if (bt[i]) begin
                    if (m_cnt[k][i] == cmax[k]) m_ovf[k][i] = 1'b1; else m_cnt[k][i]++;
                    e += longint'(ch_cost[i*8 +: 8]);
                end
            end
            if (e > emax) begin m_en[k] = emax; m_ovf[k][NCH] = 1'b1; end
            else m_en[k] = e;
            if (last) m_ph[k] = 2;
        end
        m_busy[k] = (m_ph[k] == 1);
        m_done[k] = (m_ph[k] == 2) && (prev != 2);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            model_clear(k);
            m_ph[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_rdv[k] = 0; m_rdd[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_step(k);
        end
    end

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                chk($sformatf("i%0d busy", k), 64'(busy[k]), 64'(m_busy[k]));
                chk($sformatf("i%0d done", k), 64'(done[k]), 64'(m_done[k]));
                chk($sformatf("i%0d overflow", k), 64'(ovf[k]), 64'(m_ovf[k]));
                chk($sformatf("i%0d rd_valid", k), 64'(rdv[k]), 64'(m_rdv[k]));
                chk($sformatf("i%0d rd_data", k), 64'(rdd[k]), 64'(m_rdd[k]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(logic [NCH-1:0] v, logic [NCH-1:0] r, bit st, bit sp);
        @(negedge clk);
        ch_valid = v; ch_ready = r; start = st; stop = sp; rd_en = 1'b0;
    endtask

    // Reads one value and compares it with a hand-computed literal.
    task automatic rd_lit(int k, int sel, longint exp, string nm);
        @(negedge clk);
        ch_valid = '0; start = 1'b0; stop = 1'b0;
        rd_en = 1'b1; rd_sel = 3'(sel);
        @(negedge clk);
        rd_en = 1'b0;
        chk(nm, 64'(rdd[k]), 64'(exp));
    endtask

    longint exp6 [8] = '{5, 5, 0, 5, 0, 35, 6, 0};

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: idle with traffic counts nothing
        step(5'b10101, 5'b11111, 0, 0);
        step(5'b01010, 5'b01110, 0, 0);
        step(5'b11111, 5'b11111, 0, 0);
        step(5'b00000, 5'b00000, 0, 0);
        for (int s = 0; s < 7; s++) rd_lit(0, s, 0, $sformatf("idle sel%0d", s));
        chk("idle busy", 64'(busy[0]), 64'd0);

        // 2: ch0 and ch2 beat for 10 cycles, plus a beat in the stop cycle
        step('0, 5'b11111, 1, 0);
        repeat (10) step(5'b00101, 5'b11111, 0, 0);
        step(5'b00101, 5'b11111, 0, 1);
        step('0, '0, 0, 0);
        chk("t2 done pulse", 64'(done[0]), 64'd1);
        @(negedge clk);
        chk("t2 done end", 64'(done[0]), 64'd0);
        rd_lit(0, 0, 11, "t2 beats0");
        rd_lit(0, 2, 11, "t2 beats2");
        rd_lit(0, 1, 0,  "t2 beats1");
        rd_lit(0, 5, 44, "t2 energy");
        rd_lit(0, 6, 11, "t2 cycles");

        // 3: fixed window of 8 on instance 1
        step('0, 5'b11111, 1, 0);
        repeat (12) step(5'b11111, 5'b11111, 0, 0);
        step('0, '0, 0, 0);
        for (int i = 0; i < NCH; i++) rd_lit(1, i, 8, $sformatf("t3 beats%0d", i));
        rd_lit(1, 6, 8, "t3 cycles");
        rd_lit(1, 5, 120, "t3 energy");
        chk("t3 busy", 64'(busy[1]), 64'd0);

        // 4: 4-bit counters saturate, then a new start clears them
        step('0, 5'b11111, 1, 0);
        repeat (20) step(5'b00010, 5'b11111, 0, 0);
        step('0, 5'b11111, 0, 1);
        rd_lit(2, 1, 15, "t4 beats1 sat");
        chk("t4 ovf1", 64'(ovf[2][1]), 64'd1);
        chk("t4 ovf cyc", 64'(ovf[2][6]), 64'd1);
        step('0, '0, 1, 0);
        step('0, '0, 0, 0);
        @(negedge clk);
        chk("t4 ovf cleared", 64'(ovf[2]), 64'd0);
        rd_lit(2, 1, 0, "t4 beats1 cleared");

        // 5: start+stop together in RUN, then reset mid-RUN
        repeat (3) step(5'b11111, 5'b11111, 0, 0);
        step(5'b11111, 5'b11111, 1, 1);
        step('0, '0, 0, 0);
        chk("t5 busy", 64'(busy[0]), 64'd1);
        chk("t5 no done", 64'(done[0]), 64'd0);
        rd_lit(0, 0, 0, "t5 beats0 cleared");
        step(5'b11111, 5'b11111, 0, 0);
        rst = 1'b1;
        step('0, '0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("t5 rst busy", 64'(busy[0]), 64'd0);
        rd_lit(0, 6, 0, "t5 rst cycles");
        rd_lit(0, 5, 0, "t5 rst energy");

        // 6: back-to-back reads sweeping every select in HOLD
        step('0, 5'b11111, 1, 0);
        repeat (5) step(5'b11011, 5'b01111, 0, 0);
        step('0, 5'b01111, 0, 1);
        step('0, '0, 0, 0);
        for (int s = 0; s <= 8; s++) begin
            @(negedge clk);
            if (s > 0) chk($sformatf("t6 sel%0d", s - 1), 64'(rdd[0]), 64'(exp6[s-1]));
            rd_en  = (s < 8);
            rd_sel = 3'(s);
        end
        rd_en = 1'b0;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
